command_tx_frame: RTL and testbench
===================================

# command_tx_frame

Frame transmitter for the RS422 command link. It is the transmit counterpart to the main command receiver. It takes one command (8-bit type plus 32-bit data field) over a ready/status/over handshake, builds an 8-byte frame with header and checksum, and serialises it 8N1 on the transceiver DI line. It also drives the half-duplex DE/RE_n pins. It runs in the system clock domain and is paced by the shared `uart_clk` enable pulse.

## Interface
- `BIT_TICKS`, 16: `uart_clk` pulses per bit-time; legal range 2..255.
- `HDR0`, 8'hEB: first header byte.
- `HDR1`, 8'h90: second header byte.

- `clk`  in  1  system clock; every flop is on its rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `uart_clk`  in  1  one-`clk`-wide enable pulse from the shared divider; not a clock.
- `command_tx_ready`  in  1  one-cycle request pulse.
- `command_tx`  in  8  command type, sampled when a request is accepted.
- `data_field_tx`  in  32  command parameter, sampled when a request is accepted.
- `command_tx_status`  out  1  high while a frame is in progress.
- `command_tx_over`  out  1  one-cycle pulse when the frame is complete.
- `command_tx_drop`  out  1  one-cycle pulse when a request arrives while busy.
- `uart_chip_de`  out  1  transceiver driver enable, active high.
- `uart_chip_re_n`  out  1  transceiver receiver enable, active low.
- `uart_chip_di`  out  1  serial data; idles at 1.

## Operation
- **Frame format:** HDR0, HDR1, CMD, D[31:24], D[23:16], D[15:8], D[7:0], CHK.
  - CHK = (CMD + four data bytes) mod 256; the header bytes are excluded.
- **Byte format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- **FSM states:** IDLE → LEAD → START → DATA → STOP → (next byte START | TRAIL) → IDLE.
- **IDLE:**
  - Outputs: de=0, re_n=0, di=1, status=0.
  - `command_tx_ready`=1 latches CMD and data, computes CHK, sets byte index to 0, and goes to LEAD.
- **LEAD:** de=1, re_n=1, di=1 for BIT_TICKS pulses. This is the driver turn-on guard.
- **START:** di=0 for BIT_TICKS pulses.
- **DATA:**
  - di = current byte bit[k], k=0..7.
  - Each bit lasts BIT_TICKS pulses.
- **STOP:** di=1 for BIT_TICKS pulses.
  - If byte index < 7: increment the index and go to START.
  - Otherwise go to TRAIL.
- **TRAIL:** de=1, di=1 for BIT_TICKS pulses. This is the guard until the stop bit has cleared the line.
  - On exit: de=0, re_n=0, status=0, `command_tx_over`=1 for one cycle, state=IDLE.
- **Requests while busy** (any state other than IDLE):
  - The request is ignored and `command_tx_drop` pulses in the same cycle.
  - Latched data is not modified.
- **Request on the completion cycle:** a request that arrives in the same cycle as `command_tx_over` is dropped. A new frame is accepted only from IDLE.
- **Pin constraint:** `uart_chip_re_n` always equals `uart_chip_de`, so the receiver is disabled whenever the driver is on.

## Timing
- **Reset** (synchronous; wins over everything; applies in the cycle after `rst` is sampled high, including mid-frame):
  - state=IDLE, de=0, re_n=0, di=1, status=0, over=0, drop=0.
  - Tick and bit counters and byte index = 0.
- **Acceptance at edge N:** status, de and re_n are high from cycle N+1; di stays 1.
- **Bit-time counting:**
  - The tick counter starts at 0 on each state entry and counts `uart_clk` pulses.
  - A phase ends on the clock edge that registers the BIT_TICKS-th pulse; the next phase's di value is valid from the following cycle.
  - The first LEAD tick is the first `uart_clk` pulse after acceptance.
- **Frame length:** 82 bit-times (1 lead + 80 data-frame bits + 1 trail), i.e. 82·BIT_TICKS `uart_clk` pulses.
- **`command_tx_over`:** asserted in the cycle after the 82nd bit-time ends, together with de falling.
- **Outputs:** all are registered; there are no combinational input-to-output paths.

## Structure
- **Package `cmd_frame_pkg`:**
  - HDR0/HDR1 defaults.
  - FRAME_BYTES=8.
  - FSM state encoding.
  - The checksum function (8-bit modular sum).
  - The receive side reuses the same package.
- **Sub-module `uart_tx_byte`:**
  - Inputs: `uart_clk`, BIT_TICKS, and a byte load/busy/done handshake.
  - Handles the START/DATA/STOP phases and the di shift register.
  - The top module owns LEAD/TRAIL, DE/RE_n, byte sequencing and the command handshake.

## Test plan
- **Basic frame.** BIT_TICKS=16, `uart_clk` every 2 clk; request cmd=8'h5A, data=32'h01020304.
  - DI decodes as EB 90 5A 01 02 03 04 64.
  - status is high for the whole frame; over pulses once, 82·32 clk after the first tick.
- **Checksum wrap.** cmd=8'hFF, data=32'hFFFFFFFF.
  - CHK = 0xFB.
  - The header does not affect CHK (vary HDR0 to 8'h55: CHK unchanged).
- **Busy request.** Issue a second request mid-DATA of byte 3.
  - drop pulses in the same cycle.
  - Frame contents are unchanged; only one over pulse.
- **Same-cycle request.** Request in the over cycle.
  - drop=1 and no new frame starts.
  - A request one cycle later is accepted.
- **Reset mid-frame.** Assert rst during byte 5.
  - Next cycle: de=0, re_n=0, di=1, status=0; no over pulse.
  - A following request yields a complete, correct frame.
- **DE guard.** Check the pin timing on every frame:
  - de rises one bit-time before the first start bit.
  - de falls one bit-time after the last stop bit.
  - re_n==de in every cycle.

Source files
------------

// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the RS422 command link frame (transmit and receive sides).
// Latency: n/a (constants, state encodings and the checksum helper only).
// Backpressure: n/a.
package cmd_frame_pkg;

    localparam logic [7:0] HDR0_DEF    = 8'hEB;
    localparam logic [7:0] HDR1_DEF    = 8'h90;
    localparam int         FRAME_BYTES = 8;

    // Frame-level sequencing: LEAD and TRAIL are driver guard bit-times.
    typedef enum logic [1:0] {
        FR_IDLE,
        FR_LEAD,
        FR_BYTES,
        FR_TRAIL
    } frame_state_t;

    // Per-byte 8N1 phases.
    typedef enum logic [1:0] {
        BT_IDLE,
        BT_START,
        BT_DATA,
        BT_STOP
    } byte_state_t;

    // Checksum covers CMD and the four data bytes; the header is excluded.
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [31:0] data);
        logic [7:0] sum;
        sum = cmd + data[31:24] + data[23:16] + data[15:8] + data[7:0];
        return sum;
    endfunction

endpackage

// File: rtl/command_tx_frame_if.sv
// Command handshake between a requester and the frame transmitter.
// Latency: n/a (wires only).
// Backpressure: none; requests while busy are dropped and flagged by the transmitter.
interface command_tx_frame_if;

    logic        command_tx_ready;
    logic [7:0]  command_tx;
    logic [31:0] data_field_tx;
    logic        command_tx_status;
    logic        command_tx_over;
    logic        command_tx_drop;

    modport master (
        output command_tx_ready,
        output command_tx,
        output data_field_tx,
        input  command_tx_status,
        input  command_tx_over,
        input  command_tx_drop
    );

    modport slave (
        input  command_tx_ready,
        input  command_tx,
        input  data_field_tx,
        output command_tx_status,
        output command_tx_over,
        output command_tx_drop
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser paced by the uart_clk enable: start bit, 8 data bits LSB first, stop bit.
// Latency: di changes the cycle after load; done fires on the edge that ends the stop bit.
// Backpressure: load is taken only when idle or in the done cycle, so bytes chain without gaps.
module uart_tx_byte
    import cmd_frame_pkg::*;
#(
    parameter int BIT_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_clk,
    input  logic       load,
    input  logic [7:0] byte_dat,
    output logic       busy,
    output logic       done,
    output logic       di
);

    byte_state_t state, state_nxt;
    logic [7:0]  tick_cnt, tick_nxt;
    logic [2:0]  bit_cnt, bit_nxt;
    logic [7:0]  sh, sh_nxt;
    logic        di_q, di_nxt;
    logic        tick_end;

    assign tick_end = uart_clk && (tick_cnt == 8'(BIT_TICKS - 1));
    assign busy     = (state != BT_IDLE);
    assign done     = (state == BT_STOP) && tick_end;
    assign di       = di_q;

    // Phase sequencing and the registered value of the line for the next cycle.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = sh;
        di_nxt    = di_q;
        if (busy && uart_clk) begin
            tick_nxt = tick_end ? 8'd0 : tick_cnt + 8'd1;
        end
        case (state)
            BT_IDLE: state_nxt = BT_IDLE;
            BT_START: begin
                if (tick_end) begin
                    state_nxt = BT_DATA;
                    bit_nxt   = 3'd0;
                    di_nxt    = sh[0];
                end
            end
            BT_DATA: begin
                if (tick_end) begin
                    if (bit_cnt == 3'd7) begin
                        state_nxt = BT_STOP;
                        di_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                        sh_nxt  = {1'b0, sh[7:1]};
                        di_nxt  = sh[1];
                    end
                end
            end
            BT_STOP: begin
                if (tick_end) begin
                    state_nxt = BT_IDLE;
                    di_nxt    = 1'b1;
                end
            end
            default: state_nxt = BT_IDLE;
        endcase
        // A new byte overrides the end of the stop bit so there is no idle gap.
        if (load && (!busy || done)) begin
            state_nxt = BT_START;
            tick_nxt  = 8'd0;
            bit_nxt   = 3'd0;
            sh_nxt    = byte_dat;
            di_nxt    = 1'b0;
        end
    end

    // State and datapath registers; the line idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BT_IDLE;
            tick_cnt <= 8'd0;
            bit_cnt  <= 3'd0;
            sh       <= 8'd0;
            di_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            sh       <= sh_nxt;
            di_q     <= di_nxt;
        end
    end

endmodule

// File: rtl/command_tx_frame.sv
// RS422 command frame transmitter: HDR0 HDR1 CMD D3..D0 CHK, 8N1, with DE/RE_n guard bit-times.
// Latency: status/de high the cycle after acceptance; frame spans 82 bit-times; over one cycle after.
// Backpressure: none; a request while busy (or in the over cycle) is ignored and pulses drop.
module command_tx_frame
    import cmd_frame_pkg::*;
#(
    parameter int         BIT_TICKS = 16,
    parameter logic [7:0] HDR0      = HDR0_DEF,
    parameter logic [7:0] HDR1      = HDR1_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_clk,
    command_tx_frame_if.slave         cmd_if,
    output logic                      uart_chip_de,
    output logic                      uart_chip_re_n,
    output logic                      uart_chip_di
);

    frame_state_t state, state_nxt;
    logic [7:0]   tick_cnt, tick_nxt;
    logic [2:0]   byte_idx, byte_idx_nxt;
    logic [7:0]   cmd_q, cmd_nxt;
    logic [31:0]  data_q, data_nxt;
    logic [7:0]   chk_q, chk_nxt;
    logic         de_q, de_nxt;
    logic         status_q, status_nxt;
    logic         over_q, over_nxt;
    logic         drop_q, drop_nxt;
    logic         tick_end;
    logic         req_busy;
    logic         load_byte;
    logic [2:0]   load_idx;
    logic [7:0]   load_dat;
    logic         tx_busy;
    logic         tx_done;

    assign tick_end = uart_clk && (tick_cnt == 8'(BIT_TICKS - 1));
    // The completion cycle still counts as busy so a new frame only starts from a settled IDLE.
    assign req_busy = (state != FR_IDLE) || over_q;

    // Frame sequencing, command latch and registered pin/handshake values.
    always_comb begin
        state_nxt    = state;
        tick_nxt     = tick_cnt;
        byte_idx_nxt = byte_idx;
        cmd_nxt      = cmd_q;
        data_nxt     = data_q;
        chk_nxt      = chk_q;
        de_nxt       = de_q;
        status_nxt   = status_q;
        over_nxt     = 1'b0;
        drop_nxt     = cmd_if.command_tx_ready && req_busy;
        load_byte    = 1'b0;
        load_idx     = byte_idx;
        if (((state == FR_LEAD) || (state == FR_TRAIL)) && uart_clk) begin
            tick_nxt = tick_end ? 8'd0 : tick_cnt + 8'd1;
        end
        case (state)
            FR_IDLE: begin
                if (cmd_if.command_tx_ready && !req_busy) begin
                    state_nxt    = FR_LEAD;
                    tick_nxt     = 8'd0;
                    byte_idx_nxt = 3'd0;
                    cmd_nxt      = cmd_if.command_tx;
                    data_nxt     = cmd_if.data_field_tx;
                    chk_nxt      = frame_chk(cmd_if.command_tx, cmd_if.data_field_tx);
                    de_nxt       = 1'b1;
                    status_nxt   = 1'b1;
                end
            end
            FR_LEAD: begin
                if (tick_end) begin
                    state_nxt    = FR_BYTES;
                    load_byte    = 1'b1;
                    load_idx     = 3'd0;
                    byte_idx_nxt = 3'd0;
                end
            end
            FR_BYTES: begin
                if (tx_done) begin
                    if (byte_idx == 3'(FRAME_BYTES - 1)) begin
                        state_nxt = FR_TRAIL;
                        tick_nxt  = 8'd0;
                    end else begin
                        load_byte    = 1'b1;
                        load_idx     = byte_idx + 3'd1;
                        byte_idx_nxt = byte_idx + 3'd1;
                    end
                end
            end
            FR_TRAIL: begin
                if (tick_end) begin
                    state_nxt    = FR_IDLE;
                    byte_idx_nxt = 3'd0;
                    de_nxt       = 1'b0;
                    status_nxt   = 1'b0;
                    over_nxt     = 1'b1;
                end
            end
            default: state_nxt = FR_IDLE;
        endcase
    end

    // Frame byte selected for the serialiser.
    always_comb begin
        load_dat = HDR0;
        case (load_idx)
            3'd0: load_dat = HDR0;
            3'd1: load_dat = HDR1;
            3'd2: load_dat = cmd_q;
            3'd3: load_dat = data_q[31:24];
            3'd4: load_dat = data_q[23:16];
            3'd5: load_dat = data_q[15:8];
            3'd6: load_dat = data_q[7:0];
            3'd7: load_dat = chk_q;
            default: load_dat = HDR0;
        endcase
    end

    // State and output registers; reset returns the pins to receive mode mid-frame too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FR_IDLE;
            tick_cnt <= 8'd0;
            byte_idx <= 3'd0;
            cmd_q    <= 8'd0;
            data_q   <= 32'd0;
            chk_q    <= 8'd0;
            de_q     <= 1'b0;
            status_q <= 1'b0;
            over_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            byte_idx <= byte_idx_nxt;
            cmd_q    <= cmd_nxt;
            data_q   <= data_nxt;
            chk_q    <= chk_nxt;
            de_q     <= de_nxt;
            status_q <= status_nxt;
            over_q   <= over_nxt;
            drop_q   <= drop_nxt;
        end
    end

    uart_tx_byte #(.BIT_TICKS(BIT_TICKS)) u_tx_byte (
        .clk      (clk),
        .rst      (rst),
        .uart_clk (uart_clk),
        .load     (load_byte),
        .byte_dat (load_dat),
        .busy     (tx_busy),
        .done     (tx_done),
        .di       (uart_chip_di)
    );

    // A byte is only handed over when the serialiser is idle or finishing its stop bit.
    assert property (@(posedge clk) disable iff (rst) load_byte |-> (!tx_busy || tx_done));

    // RE_n shares the DE flop so the receiver is off whenever the driver is on.
    assign uart_chip_de               = de_q;
    assign uart_chip_re_n             = de_q;
    assign cmd_if.command_tx_status   = status_q;
    assign cmd_if.command_tx_over     = over_q;
    assign cmd_if.command_tx_drop     = drop_q;

endmodule

// File: tb/tb_command_tx_frame.sv
// Bench for command_tx_frame: table of commands, busy/over-cycle/reset corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_command_tx_frame;

    localparam int BT           = 16;
    localparam int HALF_BIT_CLK = BT;         // uart_clk pulses every 2 clk
    localparam int BIT_CLK      = 2 * BT;
    localparam int FRAME_PULSES = 82 * BT;
    localparam int WAIT_MAX     = 4000;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [7:0]  chk;
    } vec_t;

    logic clk;
    logic rst;
    logic uart_clk;
    logic de_a, re_n_a, di_a;
    logic de_b, re_n_b, di_b;

    int checks = 0;
    int errors = 0;
    int over_cnt = 0;
    int pin_err = 0;
    int stat_err = 0;
    int lock_err = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    command_tx_frame_if ifa();
    command_tx_frame_if ifb();

    assign ifb.command_tx_ready = ifa.command_tx_ready;
    assign ifb.command_tx       = ifa.command_tx;
    assign ifb.data_field_tx    = ifa.data_field_tx;

    command_tx_frame #(.BIT_TICKS(BT)) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_clk       (uart_clk),
        .cmd_if         (ifa.slave),
        .uart_chip_de   (de_a),
        .uart_chip_re_n (re_n_a),
        .uart_chip_di   (di_a)
    );

    command_tx_frame #(.BIT_TICKS(BT), .HDR0(8'h55)) dut_hdr (
        .clk            (clk),
        .rst            (rst),
        .uart_clk       (uart_clk),
        .cmd_if         (ifb.slave),
        .uart_chip_de   (de_b),
        .uart_chip_re_n (re_n_b),
        .uart_chip_di   (di_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // uart_clk enable: one clk high, one clk low, changed just after the edge.
    initial begin
        uart_clk = 1'b0;
        forever begin
            @(posedge clk);
            #1 uart_clk = ~uart_clk;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_byte(input int c, input logic [7:0] b);
        logic [7:0] e;
        checks++;
        if ((c == 0 && exp_a.size() == 0) || (c == 1 && exp_b.size() == 0)) begin
            errors++;
            $display("FAIL rx_byte[%0d]: got %02h, expected no byte", c, b);
        end else begin
            if (c == 0) e = exp_a.pop_front();
            else        e = exp_b.pop_front();
            if (b !== e) begin
                errors++;
                $display("FAIL rx_byte[%0d]: got %02h, expected %02h", c, b, e);
            end
        end
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [31:0] d, input logic [7:0] k);
        exp_a.push_back(8'hEB); exp_b.push_back(8'h55);
        exp_a.push_back(8'h90); exp_b.push_back(8'h90);
        exp_a.push_back(c);     exp_b.push_back(c);
        exp_a.push_back(d[31:24]); exp_b.push_back(d[31:24]);
        exp_a.push_back(d[23:16]); exp_b.push_back(d[23:16]);
        exp_a.push_back(d[15:8]);  exp_b.push_back(d[15:8]);
        exp_a.push_back(d[7:0]);   exp_b.push_back(d[7:0]);
        exp_a.push_back(k);     exp_b.push_back(k);
    endtask

    // Called at a negedge; returns at the next negedge where registered responses are visible.
    task automatic pulse_req(input logic [7:0] c, input logic [31:0] d);
        ifa.command_tx       = c;
        ifa.data_field_tx    = d;
        ifa.command_tx_ready = 1'b1;
        @(negedge clk);
        ifa.command_tx_ready = 1'b0;
    endtask

    task automatic wait_over(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < WAIT_MAX; n++) begin
            @(negedge clk);
            if (ifa.command_tx_over) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_accept(input string tag);
        check({tag, "_status"}, ifa.command_tx_status, 1);
        check({tag, "_de"}, de_a, 1);
        check({tag, "_re_n"}, re_n_a, 1);
        check({tag, "_di_idle"}, di_a, 1);
        check({tag, "_no_drop"}, ifa.command_tx_drop, 0);
    endtask

    // Serial decoder for both DUTs: mid-bit sampling, bytes go to the scoreboard.
    bit         rx_busy[2];
    int         rx_cnt[2];
    logic [7:0] rx_sh[2];
    always @(negedge clk) begin
        logic [1:0] di_v;
        di_v = {di_b, di_a};
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                rx_busy[c] = 1'b0;
            end else if (!rx_busy[c]) begin
                if (di_v[c] == 1'b0) begin
                    rx_busy[c] = 1'b1;
                    rx_cnt[c]  = 0;
                end
            end else begin
                rx_cnt[c]++;
                if (rx_cnt[c] == HALF_BIT_CLK) begin
                    if (di_v[c] != 1'b0) begin
                        errors++;
                        $display("FAIL start_bit[%0d]: got 1, expected 0", c);
                        rx_busy[c] = 1'b0;
                    end
                end else if (rx_cnt[c] > HALF_BIT_CLK && ((rx_cnt[c] - HALF_BIT_CLK) % BIT_CLK) == 0) begin
                    if ((rx_cnt[c] - HALF_BIT_CLK) / BIT_CLK <= 8) begin
                        rx_sh[c] = {di_v[c], rx_sh[c][7:1]};
                    end else begin
                        check($sformatf("stop_bit[%0d]", c), di_v[c], 1);
                        sb_byte(c, rx_sh[c]);
                        rx_busy[c] = 1'b0;
                    end
                end
            end
        end
    end

    // Pin timing monitor: DE guard lengths, frame length, over alignment, pin invariants.
    bit fr_act = 1'b0;
    bit prev_de = 1'b0;
    bit lead_seen;
    int tick_cnt;
    int lead_ticks;
    always @(negedge clk) begin
        if (re_n_a !== de_a) pin_err++;
        if (ifa.command_tx_status !== de_a) stat_err++;
        if (de_b !== de_a || re_n_b !== re_n_a || ifb.command_tx_status !== ifa.command_tx_status ||
            ifb.command_tx_over !== ifa.command_tx_over || ifb.command_tx_drop !== ifa.command_tx_drop)
            lock_err++;
        if (ifa.command_tx_over) over_cnt++;
        if (rst) begin
            fr_act = 1'b0;
        end else if (de_a && !prev_de) begin
            fr_act    = 1'b1;
            tick_cnt  = 0;
            lead_seen = 1'b0;
            lead_ticks = 0;
        end
        if (fr_act && de_a) begin
            if (!lead_seen && di_a == 1'b0) begin
                lead_seen  = 1'b1;
                lead_ticks = tick_cnt;
            end
            if (uart_clk) tick_cnt++;
        end
        if (fr_act && !de_a && prev_de) begin
            check("lead_ticks", lead_ticks, BT);
            check("frame_ticks", tick_cnt, FRAME_PULSES);
            check("over_at_de_fall", ifa.command_tx_over, 1);
            fr_act = 1'b0;
        end
        prev_de = de_a;
    end

    initial begin
        vec_t vecs[6];
        bit   ok;
        int   frames_done;
        int   over_snap;
        vecs[0] = '{8'h5A, 32'h01020304, 8'h64};
        vecs[1] = '{8'hFF, 32'hFFFFFFFF, 8'hFB};
        vecs[2] = '{8'h00, 32'h00000000, 8'h00};
        vecs[3] = '{8'h12, 32'h3456789A, 8'hAE};
        vecs[4] = '{8'h80, 32'h80000000, 8'h00};
        vecs[5] = '{8'hA5, 32'h00FF0001, 8'hA5};
        frames_done = 0;

        rst = 1'b1;
        ifa.command_tx_ready = 1'b0;
        ifa.command_tx       = 8'h00;
        ifa.data_field_tx    = 32'h0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_de", de_a, 0);
        check("reset_re_n", re_n_a, 0);
        check("reset_di", di_a, 1);
        check("reset_status", ifa.command_tx_status, 0);
        check("reset_over", ifa.command_tx_over, 0);
        check("reset_drop", ifa.command_tx_drop, 0);

        // Table of commands, one complete frame each.
        for (int i = 0; i < 6; i++) begin
            push_frame(vecs[i].cmd, vecs[i].data, vecs[i].chk);
            pulse_req(vecs[i].cmd, vecs[i].data);
            check_accept($sformatf("vec%0d_accept", i));
            wait_over(ok);
            check($sformatf("vec%0d_over_seen", i), ok, 1);
            if (ok) frames_done++;
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_bytes_left_a", i), exp_a.size(), 0);
            check($sformatf("vec%0d_bytes_left_b", i), exp_b.size(), 0);
        end

        // Request mid-DATA of byte 3 is dropped and leaves the frame untouched.
        push_frame(8'hC7, 32'hDEADBEEF, 8'hFF);
        pulse_req(8'hC7, 32'hDEADBEEF);
        check_accept("busy_accept");
        repeat (1150) @(negedge clk);
        pulse_req(8'h11, 32'h22334455);
        check("busy_drop", ifa.command_tx_drop, 1);
        check("busy_status", ifa.command_tx_status, 1);
        @(negedge clk);
        check("busy_drop_clear", ifa.command_tx_drop, 0);
        wait_over(ok);
        check("busy_over_seen", ok, 1);
        if (ok) frames_done++;
        repeat (4) @(negedge clk);
        check("busy_bytes_left_a", exp_a.size(), 0);
        check("busy_bytes_left_b", exp_b.size(), 0);

        // Request in the over cycle is dropped; one cycle later it is accepted.
        push_frame(vecs[3].cmd, vecs[3].data, vecs[3].chk);
        pulse_req(vecs[3].cmd, vecs[3].data);
        wait_over(ok);
        check("oc_over_seen", ok, 1);
        if (ok) frames_done++;
        ifa.command_tx       = 8'h77;
        ifa.data_field_tx    = 32'h99999999;
        ifa.command_tx_ready = 1'b1;
        @(negedge clk);
        check("oc_drop", ifa.command_tx_drop, 1);
        check("oc_no_start_status", ifa.command_tx_status, 0);
        check("oc_no_start_de", de_a, 0);
        push_frame(vecs[0].cmd, vecs[0].data, vecs[0].chk);
        ifa.command_tx    = vecs[0].cmd;
        ifa.data_field_tx = vecs[0].data;
        @(negedge clk);
        ifa.command_tx_ready = 1'b0;
        check_accept("oc_next");
        wait_over(ok);
        check("oc_next_over_seen", ok, 1);
        if (ok) frames_done++;
        repeat (4) @(negedge clk);
        check("oc_bytes_left_a", exp_a.size(), 0);
        check("oc_bytes_left_b", exp_b.size(), 0);

        // Reset during byte 5 returns the pins to idle with no over pulse.
        push_frame(vecs[1].cmd, vecs[1].data, vecs[1].chk);
        pulse_req(vecs[1].cmd, vecs[1].data);
        repeat (1732) @(negedge clk);
        check("prereset_bytes_left", exp_a.size(), 3);
        over_snap = over_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_de", de_a, 0);
        check("midrst_re_n", re_n_a, 0);
        check("midrst_di", di_a, 1);
        check("midrst_status", ifa.command_tx_status, 0);
        check("midrst_over", ifa.command_tx_over, 0);
        exp_a.delete();
        exp_b.delete();
        repeat (100) @(negedge clk);
        check("midrst_no_over", over_cnt, over_snap);
        push_frame(vecs[5].cmd, vecs[5].data, vecs[5].chk);
        pulse_req(vecs[5].cmd, vecs[5].data);
        check_accept("postrst_accept");
        wait_over(ok);
        check("postrst_over_seen", ok, 1);
        if (ok) frames_done++;
        repeat (4) @(negedge clk);
        check("postrst_bytes_left_a", exp_a.size(), 0);
        check("postrst_bytes_left_b", exp_b.size(), 0);

        check("over_pulses", over_cnt, frames_done);
        check("re_n_eq_de_cycles", pin_err, 0);
        check("status_eq_de_cycles", stat_err, 0);
        check("hdr_variant_lockstep", lock_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
